// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: FP32 field positions,
// IEEE-754 class encodings, sticky flag bit positions and entry types.
package alu_pkg;

    // IEEE-754 class encodings reported on out_class
    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_SUB    = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    // FP32 field boundaries
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Bit positions inside the sticky flag vector
    localparam int STK_ZERO = 0;
    localparam int STK_SUB  = 1;
    localparam int STK_INF  = 2;
    localparam int STK_NAN  = 3;

    // One FIFO entry: captured result, its opcode and its class
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  op;
        logic [2:0]  cls;
    } entry_t;

    // One stage of the issue-tracking pipeline
    typedef struct packed {
        logic       vld;
        logic [2:0] op;
    } tag_t;

    // Map a class to the sticky bit it sets; normal values set nothing
    function automatic logic [3:0] cls_to_sticky(input logic [2:0] cls);
        logic [3:0] bits;
        bits = 4'b0000;
        case (cls)
            CLS_ZERO: bits[STK_ZERO] = 1'b1;
            CLS_SUB:  bits[STK_SUB]  = 1'b1;
            CLS_INF:  bits[STK_INF]  = 1'b1;
            CLS_NAN:  bits[STK_NAN]  = 1'b1;
            default:  bits = 4'b0000;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision classifier. The sign bit is
// ignored, so -0 is zero and -inf is inf.
module fp32_classify
    import alu_pkg::*;
(
    input  logic [31:0] value,
    output logic [2:0]  cls
);

    logic [7:0]  exp_s;
    logic [22:0] man_s;
    logic        unused_sign_s;

    assign exp_s         = value[EXP_MSB:EXP_LSB];
    assign man_s         = value[MAN_MSB:0];
    assign unused_sign_s = value[31];

    // Decode exponent/mantissa into one of the five classes
    always_comb begin
        cls = CLS_NORMAL;
        if (exp_s == 8'h00) begin
            if (man_s == 23'h000000) begin
                cls = CLS_ZERO;
            end else begin
                cls = CLS_SUB;
            end
        end else if (exp_s == EXP_MAX) begin
            if (man_s == 23'h000000) begin
                cls = CLS_INF;
            end else begin
                cls = CLS_NAN;
            end
        end else begin
            cls = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Follows each ALU issue through the fixed ALU latency, captures and
// classifies the result, and queues it in a show-ahead FIFO. Also keeps
// sticky class flags and a saturating count of results lost to a full FIFO.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [2:0]                 issue_op,
    input  logic [31:0]                alu_o,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_op,
    output logic [2:0]                 out_class,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [3:0]                 sticky,
    input  logic                       flag_clr,
    output logic [7:0]                 drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    tag_t             tag_q [ALU_LAT];
    tag_t             tag_d [ALU_LAT];
    tag_t             tail_s;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry_s;
    entry_t           head_s;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [2:0]       cap_cls_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [3:0]       sticky_set_s;

    fp32_classify u_classify (
        .value (alu_o),
        .cls   (cap_cls_s)
    );

    assign tail_s     = tag_q[ALU_LAT-1];
    assign wr_entry_s = '{data: alu_o, op: tail_s.op, cls: cap_cls_s};

    // Shift the issue tag one stage per cycle; stage 0 samples the issue port
    always_comb begin
        tag_d[0].vld = issue_valid;
        tag_d[0].op  = issue_op;
        for (int i = 1; i < ALU_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Push/pop/drop decisions and next-state for pointers, count and flags
    always_comb begin
        full_s = (count_q == CNT_W'(DEPTH));
        pop_s  = (count_q != {CNT_W{1'b0}}) && out_ready;
        // A pop frees the slot that a capture on a full FIFO writes into
        push_s = tail_s.vld && (!full_s || pop_s);
        drop_s = tail_s.vld && full_s && !pop_s;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        // Dropped results still flag their class
        if (tail_s.vld) begin
            sticky_set_s = cls_to_sticky(cap_cls_s);
        end else begin
            sticky_set_s = 4'b0000;
        end

        // Clear first, then OR in new events so a coincident set survives
        if (flag_clr) begin
            sticky_d = sticky_set_s;
        end else begin
            sticky_d = sticky_q | sticky_set_s;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                tag_q[i] <= '{vld: 1'b0, op: 3'b000};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            sticky_q   <= 4'b0000;
            drop_cnt_q <= 8'h00;
        end else begin
            for (int i = 0; i < ALU_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because reads are gated by count
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    // Show-ahead head, forced to zero while the FIFO is empty
    always_comb begin
        head_s    = mem_q[rd_ptr_q];
        out_valid = (count_q != {CNT_W{1'b0}});
        if (out_valid) begin
            out_data  = head_s.data;
            out_op    = head_s.op;
            out_class = head_s.cls;
        end else begin
            out_data  = 32'h00000000;
            out_op    = 3'b000;
            out_class = 3'b000;
        end
    end

    assign count    = count_q;
    assign sticky   = sticky_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised and directed bench for alu_result_collector. The ALU is a
// delay line; expected results come from a queue-based reference model.
module tb_alu_result_collector;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_op = 3'b000;
    logic [31:0] alu_o = 32'h00000000;
    logic        out_ready = 1'b0;
    logic        flag_clr = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_op;
    logic [2:0]  out_class;
    logic [2:0]  count;
    logic [3:0]  sticky;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    alu_result_collector #(.ALU_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .alu_o       (alu_o),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_op      (out_op),
        .out_class   (out_class),
        .count       (count),
        .sticky      (sticky),
        .flag_clr    (flag_clr),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        int          due;
        logic [2:0]  op;
        logic [31:0] val;
    } pend_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  op;
        int          cls;
    } exp_t;

    pend_t       pend_q[$];
    exp_t        mf[$];
    exp_t        exp_q[$];
    int          m_sticky = 0;
    int          m_drop = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] dl [LAT];

    function automatic int ref_class(input logic [31:0] v);
        int unsigned uv;
        int unsigned e;
        int unsigned m;
        uv = v;
        e  = (uv / 32'd8388608) % 32'd256;
        m  = uv % 32'd8388608;
        if (e == 0) return (m == 0) ? 0 : 1;
        if (e == 255) return (m == 0) ? 3 : 4;
        return 2;
    endfunction

    function automatic int class_flag(input int c);
        if (c == 0) return 1;
        if (c == 1) return 2;
        if (c == 3) return 4;
        if (c == 4) return 8;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference behaviour for one clock edge using the inputs held across it
    task automatic model_edge();
        bit    pop;
        int    set;
        int    c;
        pend_t p;
        if (rst) begin
            pend_q.delete();
            mf.delete();
            exp_q.delete();
            m_sticky = 0;
            m_drop   = 0;
            return;
        end
        set = 0;
        pop = (mf.size() > 0) && out_ready;
        if (pop) void'(mf.pop_front());
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p   = pend_q.pop_front();
            c   = ref_class(p.val);
            set = class_flag(c);
            if (mf.size() < DEPTH) begin
                mf.push_back('{data: p.val, op: p.op, cls: c});
                exp_q.push_back('{data: p.val, op: p.op, cls: c});
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        m_sticky = (flag_clr ? 0 : m_sticky) | set;
        if (issue_valid) pend_q.push_back('{due: cyc + LAT, op: issue_op, val: 32'h0});
        if (issue_valid) pend_q[pend_q.size()-1].val = dl[0];
    endtask

    // Advance one cycle: apply model for the edge, then drive the next inputs
    task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] val,
                        input logic rdy, input logic clr, input logic r);
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        rst         = r;
        issue_valid = iv;
        issue_op    = op;
        out_ready   = rdy;
        flag_clr    = clr;
        alu_o       = dl[LAT-1];
        for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = iv ? val : $urandom();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return {r[31], 8'h00, r[22:1], 1'b1};
            3: return {r[31], 8'hFF, 23'h000000};
            4: return {r[31], 8'hFF, r[22:1], 1'b1};
            default: return r;
        endcase
    endfunction

    // Scoreboard monitor: samples mid-cycle and checks every handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", {31'b0, out_valid}, {31'b0, mf.size() > 0});
                chk("count", {29'b0, count}, mf.size());
                chk("sticky", {28'b0, sticky}, m_sticky);
                chk("drop_cnt", {24'b0, drop_cnt}, m_drop);
                if (!out_valid) begin
                    chk("idle_data", out_data, 32'h0);
                    chk("idle_op_class", {26'b0, out_op, out_class}, 32'h0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("head_data", out_data, e.data);
                        chk("head_op", {29'b0, out_op}, {29'b0, e.op});
                        chk("head_class", {29'b0, out_class}, e.cls);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < LAT; i++) dl[i] = 32'h0;

        // Reset state
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_count", {29'b0, count}, 32'h0);
        chk("rst_sticky", {28'b0, sticky}, 32'h0);
        chk("rst_drop", {24'b0, drop_cnt}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Single op
        step(1'b1, 3'b001, 32'h7ACF8787, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("single_valid", {31'b0, out_valid}, 32'h1);
        chk("single_data", out_data, 32'h7ACF8787);
        chk("single_op", {29'b0, out_op}, 32'h1);
        chk("single_class", {29'b0, out_class}, 32'h2);
        chk("single_count", {29'b0, count}, 32'h1);
        chk("single_sticky", {28'b0, sticky}, 32'h0);
        step(1'b0, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Class sweep
        step(1'b1, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b011, 32'h00400000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b100, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b101, 32'h7FC00000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b110, 32'h80000000, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        chk("sweep_sticky", {28'b0, sticky}, 32'hF);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("clr_sticky", {28'b0, sticky}, 32'h0);

        // Overflow: six results into a four-deep FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 3'(i), 32'h3F800000 + 32'(i), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("ovf_count", {29'b0, count}, 32'h4);
        chk("ovf_drop", {24'b0, drop_cnt}, 32'h2);
        chk("ovf_head", out_data, 32'h3F800000);
        idle(4, 1'b1);
        idle(1, 1'b0);
        chk("drain_valid", {31'b0, out_valid}, 32'h0);
        chk("drain_data", out_data, 32'h0);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 32'h40000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 3'b101, 32'h41200000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fullpp_count", {29'b0, count}, 32'h4);
        chk("fullpp_drop", {24'b0, drop_cnt}, 32'h2);
        chk("fullpp_head", out_data, 32'h40000001);
        idle(4, 1'b1);
        idle(1, 1'b0);

        // Reset while an issue is in flight
        step(1'b1, 3'b011, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("mid_rst_count", {29'b0, count}, 32'h0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_sticky", {28'b0, sticky}, 32'h0);
        chk("mid_rst_drop", {24'b0, drop_cnt}, 32'h0);

        // Drop counter saturation
        for (int i = 0; i < 304; i++) step(1'b1, 3'b001, 32'h3F000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("sat_drop", {24'b0, drop_cnt}, 32'hFF);
        chk("sat_count", {29'b0, count}, 32'h4);

        // NaN capture on the same edge as flag_clr: set wins
        step(1'b1, 3'b100, 32'h7FC00001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("setwin_sticky", {28'b0, sticky}, 32'h8);
        chk("setwin_drop", {24'b0, drop_cnt}, 32'hFF);
        idle(4, 1'b1);
        idle(1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom()), rnd_val(),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 96) == 0));
        end
        idle(10, 1'b1);
        chk("final_count", {29'b0, count}, 32'h0);
        chk("final_scoreboard_empty", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
